victim_cache: RTL



---
 rtl/victim_cache.sv | 116 +++++++++++
 1 files changed

// File: rtl/victim_cache.sv
// victim_cache: fully-associative victim cache with FIFO replacement and one-entry dirty write-back buffer
module victim_cache #(
  parameter int VC_ENTRIES  = 4,
  parameter int ADDR_W      = 32,
  parameter int OFFSET_BITS = 4,
  parameter int LINE_W      = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_req_i,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  input  logic              kill_i,
  output logic              victim_hit_o,
  output logic [LINE_W-1:0] victim_rdata_o,
  input  logic              write_from_victim_i,
  input  logic              write_to_victim_i,
  input  logic [ADDR_W-1:0] evict_addr_i,
  input  logic [LINE_W-1:0] evict_line_i,
  input  logic              evict_dirty_i,
  output logic              vc_ready_o,
  output logic              wb_pending_o,
  output logic              vc2mem_req_o,
  output logic [ADDR_W-1:0] vc2mem_addr_o,
  output logic [LINE_W-1:0] vc2mem_wdata_o,
  input  logic              mem2vc_ack_i
);
  localparam int TAG_W = ADDR_W - OFFSET_BITS;
  localparam int IDX_W = $clog2(VC_ENTRIES);
  typedef enum logic {WB_IDLE, WB_REQ} wb_state_t;
  wb_state_t wb_state;
  logic [VC_ENTRIES-1:0] valid, dirty;
  logic [TAG_W-1:0] tags [VC_ENTRIES];
  logic [LINE_W-1:0] lines [VC_ENTRIES];
  logic [IDX_W-1:0] ptr, hit_idx, lk_idx, match_idx, inv_idx, tgt;
  logic [TAG_W-1:0] lk_tag, ev_tag;
  logic lk_hit, match_any, inv_any, swap, repl, ins, disp, load, unused;
  assign lk_tag = lookup_addr_i[ADDR_W-1:OFFSET_BITS];
  assign ev_tag = evict_addr_i[ADDR_W-1:OFFSET_BITS];
  assign unused = ^{lookup_addr_i[OFFSET_BITS-1:0], evict_addr_i[OFFSET_BITS-1:0]};
  // Descending scan so the lowest matching/invalid index wins.
  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    match_any = 1'b0;
    match_idx = '0;
    inv_any = 1'b0;
    inv_idx = '0;
    for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && tags[i] == lk_tag) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (valid[i] && tags[i] == ev_tag) begin
        match_any = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        inv_any = 1'b1;
        inv_idx = IDX_W'(i);
      end
    end
  end
  assign swap = write_from_victim_i && victim_hit_o;
  assign repl = !swap && !match_any && !inv_any;
  assign tgt = swap ? hit_idx : match_any ? match_idx : inv_any ? inv_idx : ptr;
  // A dirty victim cannot be displaced while the write-back buffer is still busy.
  assign vc_ready_o = !(repl && dirty[ptr] && wb_pending_o);
  assign ins = write_to_victim_i && vc_ready_o;
  assign disp = ins && repl;
  assign load = disp && dirty[ptr];
  assign wb_pending_o = wb_state == WB_REQ;
  assign victim_rdata_o = victim_hit_o ? lines[hit_idx] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= '0;
      dirty <= '0;
      ptr <= '0;
      victim_hit_o <= 1'b0;
      hit_idx <= '0;
    end else begin
      if (swap) valid[hit_idx] <= 1'b0;
      if (ins) begin
        valid[tgt] <= 1'b1;
        dirty[tgt] <= evict_dirty_i | (!swap && match_any && dirty[match_idx]);
      end
      if (disp) ptr <= ptr + IDX_W'(1);
      // A new lookup must not report an entry that is being consumed or displaced on this edge.
      if (kill_i) victim_hit_o <= 1'b0;
      else if (lookup_req_i) begin
        victim_hit_o <= lk_hit && !(swap && lk_idx == hit_idx) && !(disp && lk_idx == ptr);
        hit_idx <= lk_idx;
      end else if (swap || (disp && hit_idx == ptr)) victim_hit_o <= 1'b0;
    end
  always_ff @(posedge clk)
    if (ins) begin
      tags[tgt] <= ev_tag;
      lines[tgt] <= evict_line_i;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wb_state <= WB_IDLE;
      vc2mem_req_o <= 1'b0;
      vc2mem_addr_o <= '0;
      vc2mem_wdata_o <= '0;
    end else if (wb_state == WB_IDLE) begin
      if (load) begin
        wb_state <= WB_REQ;
        vc2mem_req_o <= 1'b1;
        vc2mem_addr_o <= {tags[ptr], {OFFSET_BITS{1'b0}}};
        vc2mem_wdata_o <= lines[ptr];
      end
    end else if (mem2vc_ack_i) begin
      wb_state <= WB_IDLE;
      vc2mem_req_o <= 1'b0;
    end
endmodule
